// File: rtl/injection_scheduler.sv
// Round-robin injector arbiter feeding one router local port; optional watchdog under INJ_SCHED_TIMEOUT_EN.
// Grant one edge after request; min 2 cycles/packet; stalls while DnStrFull, holds request until GntDnStr.
module injection_scheduler #(
    parameter int dataWidth   = 32,
    parameter int NUM_REQ     = 4,
    parameter int MAX_PKTS    = 1023,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           ReqUp,
    input  logic [NUM_REQ*dataWidth-1:0] PacketIn,
    output logic [NUM_REQ-1:0]           GntUp,
    input  logic                         DnStrFull,
    input  logic                         GntDnStr,
    output logic                         ReqDnStr,
    output logic [dataWidth-1:0]         PacketOut,
    output logic [15:0]                  SentCount,
    output logic                         Done,
    output logic                         Timeout
);

    if (NUM_REQ != 4) begin : g_bad_num_req
        $error("injection_scheduler supports exactly 4 requesters");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYC must fit the 8-bit watchdog");
    end

    typedef enum logic {
        IDLE,
        WAIT_DN
    } state_t;

    localparam logic [15:0] MAX_CNT = 16'(MAX_PKTS);

    state_t                 r_state;
    logic [NUM_REQ-1:0]     r_gnt;
    logic                   r_req;
    logic [dataWidth-1:0]   r_pkt;
    logic [15:0]            r_cnt;
    logic [1:0]             r_rr;

    logic                   w_win_vld;
    logic [1:0]             w_win;
    logic [dataWidth-1:0]   w_pkt;
    logic                   w_done;
    logic                   w_can_grant;

    // Scan from the highest offset down so the lowest offset from r_rr wins.
    always_comb begin
        w_win_vld = 1'b0;
        w_win     = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (ReqUp[r_rr + 2'(k)]) begin
                w_win_vld = 1'b1;
                w_win     = r_rr + 2'(k);
            end
        end
    end

    assign w_pkt       = PacketIn[w_win*dataWidth +: dataWidth];
    assign w_done      = (r_cnt == MAX_CNT);
    assign w_can_grant = w_win_vld && !w_done && !DnStrFull;

`ifdef INJ_SCHED_TIMEOUT_EN
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] r_wd;
    logic       r_timeout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_req     <= 1'b0;
            r_pkt     <= '0;
            r_cnt     <= '0;
            r_rr      <= 2'd0;
            r_wd      <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_gnt <= '0;
            case (r_state)
                IDLE: begin
                    if (w_can_grant) begin
                        r_gnt   <= NUM_REQ'(1) << w_win;
                        r_pkt   <= w_pkt;
                        r_req   <= 1'b1;
                        r_rr    <= w_win + 2'd1;
                        r_wd    <= 8'd0;
                        r_state <= WAIT_DN;
                    end
                end
                WAIT_DN: begin
                    if (GntDnStr) begin
                        r_req   <= 1'b0;
                        r_state <= IDLE;
                        if (r_cnt != MAX_CNT) begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end else if (r_wd == WD_LAST) begin
                        // Abandon the packet uncounted; the flag stays set until reset.
                        r_req     <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_wd <= r_wd + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Timeout = r_timeout;
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_req   <= 1'b0;
            r_pkt   <= '0;
            r_cnt   <= '0;
            r_rr    <= 2'd0;
        end else begin
            r_gnt <= '0;
            case (r_state)
                IDLE: begin
                    if (w_can_grant) begin
                        r_gnt   <= NUM_REQ'(1) << w_win;
                        r_pkt   <= w_pkt;
                        r_req   <= 1'b1;
                        r_rr    <= w_win + 2'd1;
                        r_state <= WAIT_DN;
                    end
                end
                WAIT_DN: begin
                    // No watchdog: wait for the router for as long as it takes.
                    if (GntDnStr) begin
                        r_req   <= 1'b0;
                        r_state <= IDLE;
                        if (r_cnt != MAX_CNT) begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Timeout = 1'b0;
`endif

    assign GntUp     = r_gnt;
    assign ReqDnStr  = r_req;
    assign PacketOut = r_pkt;
    assign SentCount = r_cnt;
    assign Done      = w_done;

endmodule

// File: tb/tb_injection_scheduler.sv
// Directed and randomized checks of injection_scheduler against a transaction-level reference model.
module tb_injection_scheduler;

    localparam int MAXP   = 1023;
    localparam int TO_CYC = 255;
`ifdef INJ_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [3:0]  ReqUp;
    logic [31:0] pk [4];
    logic [127:0] PacketIn;
    logic        DnStrFull;
    logic        GntDnStr;
    logic [3:0]  GntUp;
    logic        ReqDnStr;
    logic [31:0] PacketOut;
    logic [15:0] SentCount;
    logic        Done;
    logic        Timeout;

    logic        GntDnStr_m;
    logic [3:0]  GntUp_m;
    logic        ReqDnStr_m;
    logic [31:0] PacketOut_m;
    logic [15:0] SentCount_m;
    logic        Done_m;
    logic        Timeout_m;

    assign PacketIn   = {pk[3], pk[2], pk[1], pk[0]};
    assign GntDnStr_m = 1'b1;

    injection_scheduler dut (
        .clk(clk), .reset(reset), .ReqUp(ReqUp), .PacketIn(PacketIn),
        .GntUp(GntUp), .DnStrFull(DnStrFull), .GntDnStr(GntDnStr),
        .ReqDnStr(ReqDnStr), .PacketOut(PacketOut), .SentCount(SentCount),
        .Done(Done), .Timeout(Timeout)
    );

    injection_scheduler #(.MAX_PKTS(3)) dut_m (
        .clk(clk), .reset(reset), .ReqUp(ReqUp), .PacketIn(PacketIn),
        .GntUp(GntUp_m), .DnStrFull(DnStrFull), .GntDnStr(GntDnStr_m),
        .ReqDnStr(ReqDnStr_m), .PacketOut(PacketOut_m), .SentCount(SentCount_m),
        .Done(Done_m), .Timeout(Timeout_m)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // Reference model: one pending packet at most, rotating priority pointer.
    bit          m_busy;
    int          m_rr;
    int          m_sent;
    int          m_wait;
    logic [3:0]  m_gnt;
    logic        m_req;
    logic [31:0] m_pkt;
    logic        m_to;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_rr = 0; m_sent = 0; m_wait = 0;
        m_gnt = 4'b0; m_req = 1'b0; m_pkt = 32'h0; m_to = 1'b0;
    endtask

    task automatic model_step();
        int w;
        w = -1;
        m_gnt = 4'b0;
        if (!m_busy) begin
            if (m_sent != MAXP && !DnStrFull && ReqUp != 4'b0) begin
                for (int k = 0; k < 4; k++)
                    if (w < 0 && ReqUp[(m_rr + k) % 4]) w = (m_rr + k) % 4;
                m_gnt  = 4'b0001 << w;
                m_pkt  = pk[w];
                m_req  = 1'b1;
                m_rr   = (w + 1) % 4;
                m_busy = 1;
                m_wait = 0;
            end
        end else if (GntDnStr) begin
            m_req  = 1'b0;
            m_busy = 0;
            if (m_sent < MAXP) m_sent++;
        end else if (TO_EN) begin
            m_wait++;
            if (m_wait == TO_CYC) begin
                m_req  = 1'b0;
                m_busy = 0;
                m_to   = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        chk("GntUp",     64'(GntUp),     64'(m_gnt));
        chk("ReqDnStr",  64'(ReqDnStr),  64'(m_req));
        chk("PacketOut", 64'(PacketOut), 64'(m_pkt));
        chk("SentCount", 64'(SentCount), 64'(m_sent));
        chk("Done",      64'(Done),      64'(m_sent == MAXP));
        chk("Timeout",   64'(Timeout),   64'(m_to));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        model_reset();
        check_all();
        chk("rst_GntUp_m", 64'(GntUp_m), 64'h0);
        ReqUp = 4'b0; DnStrFull = 1'b0; GntDnStr = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [3:0] seq [$];
        logic [3:0] exp_seq [5];
        int highs;
        int ngm;
        int late_req;

        reset = 1'b0; ReqUp = 4'b0; DnStrFull = 1'b0; GntDnStr = 1'b0;
        for (int i = 0; i < 4; i++) pk[i] = 32'h0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        reset = 1'b1;

        // All four injectors requesting, router accepts one cycle after each request.
        ReqUp = 4'b1111;
        for (int c = 0; c < 4; c++) pk[c] = 32'hA000_0000 + 32'(c);
        for (int c = 0; c < 9; c++) begin
            tick();
            if (GntUp != 4'b0) seq.push_back(GntUp);
            if (c == 7) chk("sent_after_4", 64'(SentCount), 64'd4);
            GntDnStr = ReqDnStr;
        end
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        chk("rr_count", 64'(seq.size()), 64'd5);
        for (int i = 0; i < 5 && i < seq.size(); i++) chk("rr_seq", 64'(seq[i]), 64'(exp_seq[i]));

        // Downstream full blocks arbitration; release grants on the next edge.
        do_reset();
        ReqUp = 4'b0100; DnStrFull = 1'b1; pk[2] = 32'h2222_2222;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("full_nogrant", 64'(GntUp), 64'h0);
        end
        DnStrFull = 1'b0;
        tick();
        chk("full_release", 64'(GntUp), 64'b0100);

        // Input changes during WAIT_DN must not disturb the pending packet.
        do_reset();
        pk[1] = 32'h1111_AAAA; ReqUp = 4'b0010;
        tick();
        chk("hold_grant", 64'(GntUp), 64'b0010);
        chk("hold_pkt0", 64'(PacketOut), 64'h1111_AAAA);
        highs = 32'(ReqDnStr);
        ReqUp = 4'b1000; pk[1] = 32'h1111_BBBB; pk[3] = 32'h3333_CCCC;
        for (int c = 0; c < 5; c++) begin
            tick();
            highs += 32'(ReqDnStr);
            chk("hold_pkt", 64'(PacketOut), 64'h1111_AAAA);
            chk("hold_nogrant", 64'(GntUp), 64'h0);
        end
        GntDnStr = 1'b1;
        tick();
        GntDnStr = 1'b0;
        chk("hold_highs", 64'(highs), 64'd6);
        chk("hold_drop", 64'(ReqDnStr), 64'h0);
        tick();
        chk("hold_next", 64'(GntUp), 64'b1000);
        chk("hold_next_pkt", 64'(PacketOut), 64'h3333_CCCC);

        // Packet budget of three on the second instance.
        do_reset();
        ReqUp = 4'b1111;
        ngm = 0; late_req = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (GntUp_m != 4'b0) ngm++;
            if (c >= 6 && ReqDnStr_m) late_req++;
            GntDnStr = ReqDnStr;
        end
        chk("max_grants", 64'(ngm), 64'd3);
        chk("max_done", 64'(Done_m), 64'd1);
        chk("max_sent", 64'(SentCount_m), 64'd3);
        chk("max_req_after", 64'(late_req), 64'd0);

        // Router never grants: watchdog (if built in) abandons the packet.
        do_reset();
        GntDnStr = 1'b0;
        ReqUp = 4'b0001; pk[0] = 32'h0BAD_F00D;
        tick();
        ReqUp = 4'b0;
        highs = 32'(ReqDnStr);
        for (int c = 0; c < 260; c++) begin
            tick();
            highs += 32'(ReqDnStr);
        end
        chk("wd_sent", 64'(SentCount), 64'd0);
        if (TO_EN) begin
            chk("wd_highs", 64'(highs), 64'(TO_CYC));
            chk("wd_flag", 64'(Timeout), 64'd1);
            chk("wd_req", 64'(ReqDnStr), 64'd0);
        end else begin
            chk("nowd_req", 64'(ReqDnStr), 64'd1);
            chk("nowd_flag", 64'(Timeout), 64'd0);
        end

        // Reset in the middle of WAIT_DN, then arbitration restarts at injector 0.
        do_reset();
        ReqUp = 4'b1111;
        tick();
        GntDnStr = 1'b1;
        tick();
        GntDnStr = 1'b0;
        tick();
        chk("mid_grant2", 64'(GntUp), 64'b0010);
        do_reset();
        ReqUp = 4'b1111;
        tick();
        chk("mid_restart", 64'(GntUp), 64'b0001);

        // Randomized traffic with protocol-respecting injectors and a random router.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                if (GntUp[i]) ReqUp[i] = 1'b0;
                else if (!ReqUp[i] && $urandom_range(2) == 0) begin
                    pk[i]    = $urandom;
                    ReqUp[i] = 1'b1;
                end
            end
            DnStrFull = ($urandom_range(3) == 0);
            GntDnStr  = ($urandom_range(1) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/injection_scheduler.md
INJECTION_SCHEDULER -- requirements
Module: injection_scheduler

Interface
REQ-001 Parameter dataWidth, default 32, flit/packet width in bits.
REQ-002 Parameter NUM_REQ, default 4, number of injector requesters (fixed 4 in this revision).
REQ-003 Parameter MAX_PKTS, default 1023, total packet budget forwarded before the block stops granting.
REQ-004 Parameter TIMEOUT_CYC, default 255, downstream-grant watchdog limit in cycles.
REQ-005 clk  input  1  clock, all state updates on posedge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 ReqUp  input  4  per-injector request; bit i held high until GntUp[i] observed.
REQ-008 PacketIn  input  4*dataWidth  injector i packet on bits [i*dataWidth +: dataWidth], stable while ReqUp[i]=1.
REQ-009 GntUp  output  4  one-hot grant pulse to the winning injector.
REQ-010 DnStrFull  input  1  router local-port FIFO full.
REQ-011 GntDnStr  input  1  grant from router local port.
REQ-012 ReqDnStr  output  1  request to router local port.
REQ-013 PacketOut  output  dataWidth  latched packet presented to the router.
REQ-014 SentCount  output  16  packets forwarded since reset.
REQ-015 Done  output  1  high when SentCount == MAX_PKTS.
REQ-016 Timeout  output  1  sticky watchdog flag.

Function
REQ-017 The block SHALL implement a 2-state FSM: IDLE, WAIT_DN.
REQ-018 In IDLE, if Done=0, DnStrFull=0 and ReqUp!=0, the block SHALL select a winner w by round-robin search starting at pointer rr (2 bits), upward, wrapping 3->0.
REQ-019 On that edge it SHALL register GntUp=1<<w, PacketOut=PacketIn[w], ReqDnStr=1, rr=(w+1) mod 4, and go to WAIT_DN.
REQ-020 GntUp SHALL be high exactly one cycle per grant; in WAIT_DN GntUp=0.
REQ-021 In IDLE with DnStrFull=1, ReqUp=0 or Done=1, no grant SHALL be issued and all outputs hold.
REQ-022 In WAIT_DN, ReqDnStr and PacketOut SHALL be held, regardless of DnStrFull, until GntDnStr=1.
REQ-023 On GntDnStr=1 in WAIT_DN: ReqDnStr<=0, SentCount<=SentCount+1, state<=IDLE; GntDnStr in IDLE SHALL be ignored.
REQ-024 Minimum spacing SHALL be 2 cycles per packet; a request present at return to IDLE is arbitrated on the following edge.
REQ-025 SentCount SHALL saturate at MAX_PKTS; Done is combinational (SentCount==MAX_PKTS).
REQ-026 ReqUp changes during WAIT_DN SHALL not affect state or PacketOut.

Reset
REQ-027 reset=0 SHALL asynchronously force IDLE, GntUp=0, ReqDnStr=0, PacketOut=0, SentCount=0, rr=0, Timeout=0, watchdog=0.
REQ-028 Reset asserted in WAIT_DN SHALL abandon the pending packet without counting it.

Configuration
REQ-029 Macro INJ_SCHED_TIMEOUT_EN defined: an 8-bit watchdog counts cycles in WAIT_DN; at TIMEOUT_CYC without GntDnStr it SHALL drop ReqDnStr, set Timeout=1 (sticky to reset), return to IDLE, not increment SentCount; watchdog clears on entering WAIT_DN.
REQ-030 Macro undefined: no watchdog logic; Timeout tied 0; WAIT_DN waits indefinitely.

Verification
REQ-031 Reset, ReqUp=4'b1111 held, GntDnStr pulsed 1 cycle after each ReqDnStr -> GntUp sequence 0001,0010,0100,1000,0001; SentCount=4 after fourth GntDnStr.
REQ-032 ReqUp=4'b0100 with DnStrFull=1 for 10 cycles then 0 -> no GntUp during full; GntUp=0100 on first edge after release.
REQ-033 Grant injector 1, then change PacketIn[1] and raise ReqUp[3] during WAIT_DN, GntDnStr delayed 5 cycles -> PacketOut unchanged, ReqDnStr high 6 cycles, no GntUp.
REQ-034 MAX_PKTS=3, continuous requests and grants -> exactly 3 grants, Done=1, ReqDnStr stays 0 thereafter.
REQ-035 INJ_SCHED_TIMEOUT_EN, GntDnStr held 0 -> ReqDnStr drops after 255 cycles in WAIT_DN, Timeout=1, SentCount=0; without macro ReqDnStr stays high.
REQ-036 reset pulsed low mid-WAIT_DN -> all outputs 0 immediately, next grant begins search at injector 0.
